xor_req_scheduler: RTL and testbench
====================================

// Module: xor_req_scheduler
// PURPOSE
//   Shares the single XOR datapath resource (sign-XOR of quantised values)
//   between NREQ requesting channel engines. Round-robin arbitrates
//   requests, latches the winner's operands, issues them to the XOR unit,
//   waits its fixed latency, and returns the result with a one-cycle done
//   pulse. One operation is in flight at a time. Sits between the channel
//   sequencers and the XOR instance in the MCAC top level.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  11  operand/result width in bits
//   LAT    1   XOR unit latency in cycles, issue to valid xor_y (>=1)
// PORTS
//   clk         in   1           single clock, rising edge
//   reset       in   1           synchronous, active-high
//   req         in   NREQ        request per requester, level
//   a_bus       in   NREQ*WIDTH  operand A, requester k at [k*WIDTH +: WIDTH]
//   b_bus       in   NREQ*WIDTH  operand B, same packing as a_bus
//   gnt         out  NREQ        one-hot grant, held from ISSUE through DONE
//   done        out  NREQ        one-cycle pulse to granted requester
//   result      out  WIDTH       last XOR result, valid with done, held until next
//   xor_a       out  WIDTH       operand A to shared XOR unit
//   xor_b       out  WIDTH       operand B to shared XOR unit
//   xor_issue   out  1           one-cycle start strobe to XOR unit
//   xor_y       in   WIDTH       XOR unit result, valid LAT cycles after issue
//   busy        out  1           high in any state other than IDLE
//   test_mode   in   1           1 = fixed-priority arbitration (ATPG)
//   scan_enable in   1           DFT only; no functional effect
//   scan_in0..4 in   1           DFT only; chains stitched at synthesis
//   scan_out0..4 out 1           driven 1'b0 in RTL
// BEHAVIOUR
//   Reset (clk edge with reset=1): state=IDLE, gnt=0, done=0, xor_issue=0,
//     xor_a=xor_b=0, result=0, rr pointer=0, wait counter=0. Reset
//     mid-operation aborts the in-flight op; no done is pulsed for it.
//   FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
//   IDLE: if |req, pick winner k = first set req at or after pointer,
//     wrapping NREQ-1 -> 0; latch a_bus/b_bus slice k into xor_a/xor_b,
//     set gnt[k], go ISSUE. If req==0, stay in IDLE.
//   ISSUE (1 cycle): xor_issue=1; counter loads LAT-1; go WAIT.
//   WAIT (LAT cycles): counter decrements; at 0, capture result<=xor_y,
//     go DONE.
//   DONE (1 cycle): done[k]=1, gnt[k] still 1; pointer<=(k+1) mod NREQ;
//     next cycle gnt=0, state=IDLE.
//   Latency: req first sampled at edge c -> xor_issue high in cycle c+1,
//     done high in cycle c+2+LAT. Back-to-back throughput: one op per
//     LAT+3 cycles.
//   Operands are sampled only at grant; later changes to a_bus/b_bus or
//     deassertion of req are ignored and the op still completes with done.
//   A requester must drop req in the cycle after done, or it is
//     re-arbitrated as a new request.
//   New requests arriving outside IDLE wait; they are not lost while held.
//   test_mode=1: pointer forced to 0 each grant (lowest index wins).
//   result is the unmodified WIDTH-bit xor_y; no width conversion.
//   gnt and done are never multi-hot; xor_issue is never high outside ISSUE.
// TESTING
//   1 Single op: LAT=1, req=0001, A=11'h5A5, B=11'h0FF, XOR model returns
//     A^B -> issue at c+1, done[0] at c+3, result=11'h55A.
//   2 Round robin: req=1111 held -> grants 0,1,2,3,0 in order, each done
//     LAT+3 cycles apart; no requester skipped.
//   3 Wrap/pointer: last grant=3, then req=1001 -> grant 0 next; after it,
//     req=1001 -> grant 3.
//   4 Reset mid-op: assert reset during WAIT -> next cycle gnt=0, done=0,
//     busy=0, result=0; no done pulse for the aborted op.
//   5 Operand/req change after grant: toggle a_bus and drop req during
//     WAIT -> result uses latched operands, done still pulses.
//   6 test_mode=1 with req=1110 repeatedly held -> grant always 1; LAT=3
//     build gives done at c+5.

Source files
------------

// File: rtl/xor_req_scheduler.sv
// Round-robin scheduler sharing one XOR datapath between NREQ channel engines.
// One op in flight: grant/latch operands, issue, wait LAT cycles, pulse done.
module xor_req_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 11,
  parameter int LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      xor_a,
  output logic [WIDTH-1:0]      xor_b,
  output logic                  xor_issue,
  input  logic [WIDTH-1:0]      xor_y,
  output logic                  busy,
  input  logic                  test_mode,
  input  logic                  scan_enable,
  input  logic                  scan_in0,
  input  logic                  scan_in1,
  input  logic                  scan_in2,
  input  logic                  scan_in3,
  input  logic                  scan_in4,
  output logic                  scan_out0,
  output logic                  scan_out1,
  output logic                  scan_out2,
  output logic                  scan_out3,
  output logic                  scan_out4
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [PW-1:0]              rr_ptr, eff_ptr, win_idx, gnt_idx;
  logic                       win_found;
  logic [CW-1:0]              cnt;
  int                         j;

  assign a_arr = a_bus;
  assign b_arr = b_bus;

  // ATPG wants a deterministic winner, so the search always starts at 0.
  assign eff_ptr = test_mode ? '0 : rr_ptr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(eff_ptr) + i) % NREQ;
      if (!win_found && req[j[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    xor_issue = (state == S_ISSUE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE) ? gnt : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      xor_a   <= '0;
      xor_b   <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_found) begin
          xor_a   <= a_arr[win_idx];
          xor_b   <= b_arr[win_idx];
          gnt     <= NREQ'(1) << win_idx;
          gnt_idx <= win_idx;
        end
        S_ISSUE: cnt <= CW'(LAT - 1);
        S_WAIT: begin
          if (cnt == '0) result <= xor_y;
          else           cnt    <= cnt - CW'(1);
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Scan chains are stitched at synthesis; RTL only ties the outputs off.
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = &{1'b0, scan_enable, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};
endmodule

// File: tb/tb_xor_req_scheduler.sv
// Scoreboard bench: abstract arbitration model pushes expected ops, negedge monitor pops on done.
module tb_xor_req_scheduler;
  localparam int NREQ = 4, WIDTH = 11, LAT = 1;

  logic clk = 1'b0;
  logic reset, xor_issue, busy, test_mode, scan_enable;
  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [NREQ-1:0] req, gnt, done;
  logic [NREQ*WIDTH-1:0] a_bus, b_bus;
  logic [WIDTH-1:0] result, xor_a, xor_b, xor_y;

  always #5 clk = ~clk;

  xor_req_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .done(done), .result(result), .xor_a(xor_a), .xor_b(xor_b),
    .xor_issue(xor_issue), .xor_y(xor_y), .busy(busy), .test_mode(test_mode),
    .scan_enable(scan_enable), .scan_in0(scan_in0), .scan_in1(scan_in1),
    .scan_in2(scan_in2), .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  // Shared XOR unit: garbage except exactly LAT cycles after an issue.
  logic [WIDTH-1:0] ypipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) ypipe[i] <= ypipe[i-1];
    ypipe[0] <= xor_issue ? (xor_a ^ xor_b) : WIDTH'($urandom);
  end
  assign xor_y = ypipe[LAT-1];

  typedef struct {int idx; logic [WIDTH-1:0] res; int dcyc;} exp_t;
  exp_t sbq[$];

  int cyc = 0, free_at = 0, ptr = 0, cur_k = -1, grant_edge = -100;
  int n_cmp = 0, n_err = 0;
  int m_base, m_j, m_k;
  bit m_found, rst_last, exp_busy, exp_issue;
  logic [NREQ-1:0] exp_gnt;
  logic [WIDTH-1:0] last_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an op granted at edge g occupies the resource until edge g+LAT+3.
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_last = reset;
    if (reset) begin
      sbq.delete();
      free_at = cyc + 1; ptr = 0; cur_k = -1; grant_edge = -100;
    end else if (cyc >= free_at && req != '0) begin
      m_base = test_mode ? 0 : ptr;
      m_found = 0; m_k = 0;
      for (int i = 0; i < NREQ; i++) begin
        m_j = (m_base + i) % NREQ;
        if (!m_found && req[m_j]) begin m_k = m_j; m_found = 1; end
      end
      sbq.push_back('{m_k, a_bus[m_k*WIDTH +: WIDTH] ^ b_bus[m_k*WIDTH +: WIDTH], cyc + 1 + LAT});
      ptr = (m_k + 1) % NREQ;
      free_at = cyc + LAT + 3; cur_k = m_k; grant_edge = cyc;
    end
    exp_busy  = (cyc < free_at - 1);
    exp_issue = (cyc == grant_edge);
    exp_gnt   = exp_busy ? NREQ'(1) << cur_k : '0;
  end

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_last) begin
      chk("reset_state", {gnt, done, busy, xor_issue, result, xor_a, xor_b}, '0);
      last_res = '0;
    end else begin
      chk("ctrl_gnt_busy_issue", {gnt, busy, xor_issue}, {exp_gnt, exp_busy, exp_issue});
      if (done != '0) begin
        if (sbq.size() == 0) chk("spurious_done", done, '0);
        else begin
          e = sbq.pop_front();
          chk("done_vec", done, NREQ'(1) << e.idx);
          chk("done_result", result, e.res);
          chk("done_cycle", cyc, e.dcyc);
          last_res = e.res;
        end
      end else begin
        chk("result_hold", result, last_res);
        if (sbq.size() > 0 && cyc > sbq[0].dcyc) begin
          e = sbq.pop_front();
          chk("missed_done", 0, 1);
        end
      end
    end
  end

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++) begin
      a_bus[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      b_bus[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin rand_ops(); @(negedge clk); end
  endtask

  task automatic pulse_reset();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
  endtask

  int t;
  initial begin
    reset = 1'b1; req = '0; a_bus = '0; b_bus = '0; test_mode = 1'b0; scan_enable = 1'b0;
    scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single op with known operands and latency
    a_bus[0 +: WIDTH] = 11'h5A5; b_bus[0 +: WIDTH] = 11'h0FF; req = 4'b0001;
    t = 0;
    while (done[0] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("t1_latency", t, 2 + LAT);
    chk("t1_result", result, 11'h55A);
    req = '0;
    hold(3);

    // all requesting: rotation checked by scoreboard
    req = 4'b1111;
    hold(5 * (LAT + 3));
    req = 4'b1001;
    hold(4 * (LAT + 3));
    req = '0;
    hold(4);

    // reset during WAIT aborts the op
    req = 4'b0010;
    repeat (2) @(negedge clk);
    chk("t4_in_wait", {busy, xor_issue}, 2'b10);
    req = '0;
    pulse_reset();
    hold(3);

    // operands and req change after grant are ignored
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    hold(LAT + 4);

    // fixed priority
    test_mode = 1'b1;
    req = 4'b1110;
    hold(4 * (LAT + 3));
    req = '0;
    hold(3);
    test_mode = 1'b0;
    pulse_reset();

    // random traffic
    repeat (600) begin
      for (int k = 0; k < NREQ; k++)
        if ($urandom_range(3) == 0) req[k] = ~req[k];
      rand_ops();
      if ($urandom_range(149) == 0) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    req = '0;
    hold(LAT + 8);
    chk("drain_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
